// File: rtl/experiment_frame_mux_if.sv
// Bundle between the register wrapper and the experiment core: command strobe/data
// toward the mux, plus the operand/start/done/result link to the experiment.
interface experiment_frame_mux_if #(
  parameter int OPERAND_COUNT = 2,
  parameter int OPERAND_WIDTH = 16,
  parameter int RESULT_COUNT  = 1,
  parameter int RESULT_WIDTH  = 32
);
  logic                                         commit;
  logic [31:0]                                  command;
  logic [31:0]                                  data_in;
  logic [31:0]                                  data_out;
  logic                                         cmd_ack;
  logic                                         cmd_error;
  logic [OPERAND_COUNT-1:0][OPERAND_WIDTH-1:0]  operands;
  logic                                         start;
  logic                                         done;
  logic [RESULT_COUNT-1:0][RESULT_WIDTH-1:0]    results;

  modport master (
    output commit, command, data_in, done, results,
    input  data_out, cmd_ack, cmd_error, operands, start
  );

  modport slave (
    input  commit, command, data_in, done, results,
    output data_out, cmd_ack, cmd_error, operands, start
  );
endinterface

// File: rtl/experiment_frame_mux.sv
// Multi-frame operand/result store with command decode, start/done launch, run
// latency capture and timeout abort for one experiment core.
package experiment_frame_mux_pkg;
  localparam logic [15:0] WRITE_OP    = 16'd1;
  localparam logic [15:0] READ_RESULT = 16'd2;
  localparam logic [15:0] START_FRAME = 16'd3;
  localparam logic [15:0] READ_STATUS = 16'd4;
  localparam logic [15:0] CLEAR       = 16'd5;
endpackage

module experiment_frame_mux
  import experiment_frame_mux_pkg::*;
#(
  parameter int FRAME_COUNT    = 4,
  parameter int OPERAND_COUNT  = 2,
  parameter int OPERAND_WIDTH  = 16,
  parameter int RESULT_COUNT   = 1,
  parameter int RESULT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   rst,
  experiment_frame_mux_if.slave bus
);
  localparam int FW = (FRAME_COUNT   > 1) ? $clog2(FRAME_COUNT)   : 1;
  localparam int OW = (OPERAND_COUNT > 1) ? $clog2(OPERAND_COUNT) : 1;
  localparam int RW = (RESULT_COUNT  > 1) ? $clog2(RESULT_COUNT)  : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic [OPERAND_COUNT-1:0][OPERAND_WIDTH-1:0] op_bank  [FRAME_COUNT];
  logic [RESULT_COUNT-1:0][RESULT_WIDTH-1:0]   res_bank [FRAME_COUNT];

  logic        state;
  logic        commit_q;
  logic [15:0] cnt;
  logic [15:0] latency;
  logic [7:0]  active_frame;
  logic        sticky_err;
  logic        timeout_flag;
  logic        start_q;
  logic [31:0] data_out_q;
  logic        ack_q;
  logic        err_q;

  logic [15:0] cmd_op;
  logic [7:0]  cmd_frame;
  logic [7:0]  cmd_index;
  logic        cmd_fire;
  logic        frame_ok;
  logic        op_idx_ok;
  logic        res_idx_ok;
  logic        reject;
  logic [31:0] status;

  assign cmd_op     = bus.command[15:0];
  assign cmd_frame  = bus.command[23:16];
  assign cmd_index  = bus.command[31:24];
  assign cmd_fire   = bus.commit & ~commit_q;
  assign frame_ok   = {24'd0, cmd_frame} < 32'(FRAME_COUNT);
  assign op_idx_ok  = {24'd0, cmd_index} < 32'(OPERAND_COUNT);
  assign res_idx_ok = {24'd0, cmd_index} < 32'(RESULT_COUNT);
  assign status     = {latency, active_frame, 5'b0, timeout_flag, sticky_err, state == RUN};

  always_comb begin
    reject = 1'b0;
    case (cmd_op)
      // The running frame's operands must not move under the experiment.
      WRITE_OP:    reject = !frame_ok || !op_idx_ok || (state == RUN && cmd_frame == active_frame);
      READ_RESULT: reject = !frame_ok || !res_idx_ok;
      START_FRAME: reject = (state == RUN) || !frame_ok;
      READ_STATUS: reject = 1'b0;
      CLEAR:       reject = 1'b0;
      default:     reject = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      commit_q     <= 1'b0;
      cnt          <= '0;
      latency      <= '0;
      active_frame <= '0;
      sticky_err   <= 1'b0;
      timeout_flag <= 1'b0;
      start_q      <= 1'b0;
      data_out_q   <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      for (int f = 0; f < FRAME_COUNT; f++) begin
        op_bank[f]  <= '0;
        res_bank[f] <= '0;
      end
    end else begin
      commit_q <= bus.commit;
      start_q  <= 1'b0;
      if (!bus.commit) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
      end

      if (state == RUN) begin
        cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        // done beats a timeout landing on the same edge.
        if (bus.done) begin
          res_bank[active_frame[FW-1:0]] <= bus.results;
          latency <= cnt + 16'd1;
          state   <= IDLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state        <= IDLE;
          timeout_flag <= 1'b1;
          sticky_err   <= 1'b1;
        end
      end

      // Commands see pre-edge state; later writes here override the run logic above.
      if (cmd_fire) begin
        ack_q <= 1'b1;
        err_q <= reject;
        if (reject) begin
          sticky_err <= 1'b1;
          if (cmd_op == READ_RESULT) data_out_q <= '0;
        end else begin
          case (cmd_op)
            WRITE_OP:
              op_bank[cmd_frame[FW-1:0]][cmd_index[OW-1:0]] <= bus.data_in[OPERAND_WIDTH-1:0];
            READ_RESULT:
              data_out_q <= 32'(res_bank[cmd_frame[FW-1:0]][cmd_index[RW-1:0]]);
            START_FRAME: begin
              active_frame <= cmd_frame;
              state        <= RUN;
              cnt          <= '0;
              start_q      <= 1'b1;
            end
            READ_STATUS:
              data_out_q <= status;
            CLEAR: begin
              sticky_err   <= 1'b0;
              timeout_flag <= 1'b0;
              state        <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.cmd_ack   = ack_q;
  assign bus.cmd_error = err_q;
  assign bus.start     = start_q;
  assign bus.operands  = op_bank[active_frame[FW-1:0]];

endmodule
